// File: rtl/spi_txn_sequencer_if.sv
// Client-side command and response streams of spi_txn_sequencer.
// The sequencer uses the slave modport; the client uses the master modport.
interface spi_txn_sequencer_if #(
  parameter int SLAVE_COUNT = 4
);
  localparam int AW = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_len;
  logic [1:0]    cmd_mode;
  logic [31:0]   cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic [31:0]   rsp_data;
  logic          rsp_err;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_mode, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_addr, rsp_data, rsp_err,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_mode, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_addr, rsp_data, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/spi_txn_sequencer.sv
// Command-queue front end for the SPI master: buffers commands, launches each one
// with a txn_en pulse, tracks busy_m and returns length-masked responses in order.
module spi_txn_sequencer #(
  parameter int SLAVE_COUNT = 4,
  parameter int CMD_DEPTH   = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int START_TO    = 16,
  localparam int AW = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  spi_txn_sequencer_if.slave        bus,
  output logic                      txn_en,
  output logic [AW-1:0]             s_addr,
  output logic [1:0]                txn_len,
  output logic [1:0]                spi_mode,
  output logic [31:0]               tx_data_m,
  input  logic                      busy_m,
  input  logic [31:0]               rx_data_m,
  output logic                      seq_busy
);
  localparam int CAW   = $clog2(CMD_DEPTH);
  localparam int RAW   = $clog2(RSP_DEPTH);
  localparam int TW    = $clog2(START_TO + 1);
  localparam int CMD_W = AW + 36;
  localparam int RSP_W = AW + 33;

  localparam logic [CAW-1:0] CPTR_ONE  = CAW'(1);
  localparam logic [CAW:0]   CCNT_ONE  = (CAW + 1)'(1);
  localparam logic [CAW:0]   CCNT_ZERO = (CAW + 1)'(0);
  localparam logic [CAW:0]   CCNT_FULL = (CAW + 1)'(CMD_DEPTH);
  localparam logic [RAW-1:0] RPTR_ONE  = RAW'(1);
  localparam logic [RAW:0]   RCNT_ONE  = (RAW + 1)'(1);
  localparam logic [RAW:0]   RCNT_ZERO = (RAW + 1)'(0);
  localparam logic [RAW:0]   RCNT_FULL = (RAW + 1)'(RSP_DEPTH);
  localparam logic [TW-1:0]  TO_ONE    = TW'(1);
  localparam logic [TW-1:0]  TO_LIMIT  = TW'(START_TO);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_CAPTURE    = 3'd4
  } state_t;

  function automatic logic [31:0] len_mask(input logic [1:0] len);
    logic [31:0] m;
    case (len)
      2'b00:   m = 32'h0000_00FF;
      2'b01:   m = 32'h0000_FFFF;
      2'b10:   m = 32'h00FF_FFFF;
      2'b11:   m = 32'hFFFF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  logic [CMD_W-1:0] cmd_mem_r [CMD_DEPTH];
  logic [CAW-1:0]   cmd_wr_r, cmd_rd_r;
  logic [CAW:0]     cmd_cnt_r;
  logic             cmd_full_s, cmd_empty_s, cmd_push_s, cmd_pop_s;

  logic [RSP_W-1:0] rsp_mem_r [RSP_DEPTH];
  logic [RAW-1:0]   rsp_wr_r, rsp_rd_r;
  logic [RAW:0]     rsp_cnt_r;
  logic             rsp_full_s, rsp_empty_s, rsp_push_s, rsp_pop_s;
  logic [RSP_W-1:0] rsp_wdata_s, rsp_head_s;

  state_t           state_r;
  logic             txn_en_r;
  logic [AW-1:0]    s_addr_r;
  logic [1:0]       txn_len_r, spi_mode_r;
  logic [31:0]      tx_data_r;
  logic [TW-1:0]    to_cnt_r;
  logic             err_r;

  assign cmd_full_s  = (cmd_cnt_r == CCNT_FULL);
  assign cmd_empty_s = (cmd_cnt_r == CCNT_ZERO);
  assign cmd_push_s  = bus.cmd_valid && !cmd_full_s;
  assign cmd_pop_s   = (state_r == ST_IDLE) && !cmd_empty_s;

  assign rsp_full_s  = (rsp_cnt_r == RCNT_FULL);
  assign rsp_empty_s = (rsp_cnt_r == RCNT_ZERO);
  assign rsp_push_s  = (state_r == ST_CAPTURE) && !rsp_full_s;
  assign rsp_pop_s   = !rsp_empty_s && bus.rsp_ready;
  // A timed-out transaction never received anything, so its data is forced to zero.
  assign rsp_wdata_s = {s_addr_r, err_r, err_r ? 32'h0000_0000 : (rx_data_m & len_mask(txn_len_r))};
  assign rsp_head_s  = rsp_mem_r[rsp_rd_r];

  assign bus.cmd_ready = !cmd_full_s;
  assign bus.rsp_valid = !rsp_empty_s;
  assign bus.rsp_addr  = rsp_empty_s ? {AW{1'b0}} : rsp_head_s[RSP_W-1 -: AW];
  assign bus.rsp_err   = rsp_empty_s ? 1'b0 : rsp_head_s[32];
  assign bus.rsp_data  = rsp_empty_s ? 32'h0000_0000 : rsp_head_s[31:0];

  assign txn_en    = txn_en_r;
  assign s_addr    = s_addr_r;
  assign txn_len   = txn_len_r;
  assign spi_mode  = spi_mode_r;
  assign tx_data_m = tx_data_r;
  assign seq_busy  = (state_r != ST_IDLE);

  // Command FIFO storage write.
  always_ff @(posedge sys_clk) begin
    if (cmd_push_s) begin
      cmd_mem_r[cmd_wr_r] <= {bus.cmd_addr, bus.cmd_len, bus.cmd_mode, bus.cmd_data};
    end
  end

  // Command FIFO pointers and occupancy.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cmd_wr_r  <= {CAW{1'b0}};
      cmd_rd_r  <= {CAW{1'b0}};
      cmd_cnt_r <= CCNT_ZERO;
    end else begin
      if (cmd_push_s) cmd_wr_r <= cmd_wr_r + CPTR_ONE;
      if (cmd_pop_s)  cmd_rd_r <= cmd_rd_r + CPTR_ONE;
      case ({cmd_push_s, cmd_pop_s})
        2'b10:   cmd_cnt_r <= cmd_cnt_r + CCNT_ONE;
        2'b01:   cmd_cnt_r <= cmd_cnt_r - CCNT_ONE;
        default: cmd_cnt_r <= cmd_cnt_r;
      endcase
    end
  end

  // Response FIFO storage write.
  always_ff @(posedge sys_clk) begin
    if (rsp_push_s) begin
      rsp_mem_r[rsp_wr_r] <= rsp_wdata_s;
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rsp_wr_r  <= {RAW{1'b0}};
      rsp_rd_r  <= {RAW{1'b0}};
      rsp_cnt_r <= RCNT_ZERO;
    end else begin
      if (rsp_push_s) rsp_wr_r <= rsp_wr_r + RPTR_ONE;
      if (rsp_pop_s)  rsp_rd_r <= rsp_rd_r + RPTR_ONE;
      case ({rsp_push_s, rsp_pop_s})
        2'b10:   rsp_cnt_r <= rsp_cnt_r + RCNT_ONE;
        2'b01:   rsp_cnt_r <= rsp_cnt_r - RCNT_ONE;
        default: rsp_cnt_r <= rsp_cnt_r;
      endcase
    end
  end

  // Transaction sequencer: launch, start timeout, completion and capture.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      txn_en_r   <= 1'b0;
      s_addr_r   <= {AW{1'b0}};
      txn_len_r  <= 2'b00;
      spi_mode_r <= 2'b00;
      tx_data_r  <= 32'h0000_0000;
      to_cnt_r   <= {TW{1'b0}};
      err_r      <= 1'b0;
    end else begin
      txn_en_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!cmd_empty_s) begin
            {s_addr_r, txn_len_r, spi_mode_r, tx_data_r} <= cmd_mem_r[cmd_rd_r];
            txn_en_r <= 1'b1;
            state_r  <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          to_cnt_r <= {TW{1'b0}};
          err_r    <= 1'b0;
          state_r  <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          // busy_m is checked first so a rise on the final count still wins.
          if (busy_m) begin
            state_r <= ST_WAIT_DONE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
            if ((to_cnt_r + TO_ONE) == TO_LIMIT) begin
              err_r   <= 1'b1;
              state_r <= ST_CAPTURE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (!busy_m) begin
            err_r   <= 1'b0;
            state_r <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (!rsp_full_s) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
endmodule
